seq_divider: RTL and testbench

Multi-cycle unsigned N-bit integer divider for the arithmetic datapath, the inverse of the N-bit multiplier. It computes quotient and remainder with a restoring shift-subtract algorithm, one quotient bit per clock. A start/busy/done handshake controls it. The per-iteration trial subtraction uses a ripple chain of full-adder cells with the divisor inverted and carry-in of 1, so the block reuses the team's existing adder cell.

---
 rtl/div_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/ripple_subtractor.sv | 28 ++
 rtl/seq_divider.sv | 165 ++++++++++++++++
 tb/tb_seq_divider.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build ripple-carry arithmetic chains.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_subtractor.sv
// W-bit ripple subtractor: a - b as a + ~b + 1 through a chain of full-adder cells.
module ripple_subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  logic [W:0] carry_s;

  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_cell
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry_s[i]),
      .sum  (diff[i]),
      .cout (carry_s[i+1])
    );
  end

  // Carry out of the top cell set means a >= b, so no borrow occurred.
  assign no_borrow = carry_s[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and divide-by-zero reporting.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t    state_r;
  div_state_t    state_nx_s;
  logic [N:0]    a_r;
  logic [N-1:0]  q_r;
  logic [N-1:0]  b_r;
  logic [CW-1:0] cnt_r;

  logic          accept_s;
  logic          zero_div_s;
  logic          last_s;
  logic [N:0]    t_s;
  logic [N:0]    diff_s;
  logic          no_borrow_s;
  logic [N:0]    a_nx_s;
  logic [N-1:0]  q_nx_s;

  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  quotient_r;
  logic [N-1:0]  remainder_r;
  logic          dbz_r;

  // Shifted partial remainder; the bit shifted out of A is always zero.
  assign t_s = (a_r << 1) | {{N{1'b0}}, q_r[N-1]};

  ripple_subtractor #(
    .W (N + 1)
  ) u_sub (
    .a         (t_s),
    .b         ({1'b0, b_r}),
    .diff      (diff_s),
    .no_borrow (no_borrow_s)
  );

  // Restore-or-keep selection and quotient bit shift-in.
  always_comb begin
    q_nx_s = {q_r[N-2:0], no_borrow_s};
    if (no_borrow_s) begin
      a_nx_s = diff_s;
    end else begin
      a_nx_s = t_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    zero_div_s = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (divisor == {N{1'b0}}) begin
            zero_div_s = 1'b1;
            state_nx_s = DONE;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          last_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= {(N+1){1'b0}};
      q_r         <= {N{1'b0}};
      b_r         <= {N{1'b0}};
      cnt_r       <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {N{1'b0}};
      remainder_r <= {N{1'b0}};
      dbz_r       <= 1'b0;
    end else if (accept_s) begin
      a_r   <= {(N+1){1'b0}};
      q_r   <= dividend;
      b_r   <= divisor;
      cnt_r <= {CW{1'b0}};
      if (zero_div_s) begin
        busy_r      <= 1'b0;
        done_r      <= 1'b1;
        quotient_r  <= {N{1'b1}};
        remainder_r <= dividend;
        dbz_r       <= 1'b1;
      end else begin
        busy_r      <= 1'b1;
        done_r      <= 1'b0;
        quotient_r  <= {N{1'b0}};
        remainder_r <= {N{1'b0}};
        dbz_r       <= 1'b0;
      end
    end else if (state_r == RUN) begin
      a_r   <= a_nx_s;
      q_r   <= q_nx_s;
      cnt_r <= cnt_r + CNT_ONE;
      if (last_s) begin
        busy_r      <= 1'b0;
        done_r      <= 1'b1;
        quotient_r  <= q_nx_s;
        remainder_r <= a_nx_s[N-1:0];
      end else begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, random operands
// against an arithmetic reference, and multi-cycle handshake corner cases.
module tb_seq_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_checks;
  int n_fail;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full division from the accepting edge to the IDLE cycle after done.
  // With poke set, a 50/5 start pulse is driven during iteration 3.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic ez, input logic poke, input string tag);
    int busy_n, done_n, done_at;
    logic [N-1:0] gq, gr;
    logic gz;
    busy_n = 0; done_n = 0; done_at = -1;
    gq = '0; gr = '0; gz = 1'b0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!ez) begin
      chk({tag, " clr_q"}, quotient, 0);
      chk({tag, " clr_r"}, remainder, 0);
    end
    for (int i = 0; i <= N + 1; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++; done_at = i;
        gq = quotient; gr = remainder; gz = div_by_zero;
      end
      if (poke && i == 3) begin
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, " done_pulses"}, done_n, 1);
    chk({tag, " done_cycle"}, done_at, ez ? 0 : N);
    chk({tag, " busy_cycles"}, busy_n, ez ? 0 : N);
    chk({tag, " quotient"}, gq, eq);
    chk({tag, " remainder"}, gr, er);
    chk({tag, " dbz"}, gz, ez);
    chk({tag, " q_hold"}, quotient, eq);
  endtask

  vec_t tbl[6];

  initial begin
    int a, b, eq, er, ez, done_n;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

    tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    tbl[3] = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0};
    tbl[4] = '{8'd37,  8'd0,   8'hFF,  8'd37, 1'b1};
    tbl[5] = '{8'd255, 8'd16,  8'd15,  8'd15, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst dbz", div_by_zero, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 1'b0,
              $sformatf("vec%0d", i));
    end

    // Start pulse mid-flight must be ignored.
    run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1, "ignored_start");

    // Reset during iteration 4 aborts without a done pulse.
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort dbz", div_by_zero, 0);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_n++;
    end
    chk("abort no_done", done_n, 0);
    run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 1'b0, "after_abort");

    // Start held high: one division every N+2 cycles.
    @(negedge clk);
    dividend = 8'd17; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    done_n = 0;
    for (int i = 0; i < 3 * (N + 2); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("held done@%0d", i), done, (i % (N + 2)) == N);
      chk($sformatf("held busy@%0d", i), busy, (i % (N + 2)) < N);
      if (done) begin
        done_n++;
        chk("held quotient", quotient, 5);
        chk("held remainder", remainder, 2);
      end
    end
    start = 1'b0;
    chk("held done_pulses", done_n, 3);
    @(posedge clk); #1;

    // Random operands against plain integer division.
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      if (b == 0) begin
        eq = 255; er = a; ez = 1;
      end else begin
        eq = a / b; er = a % b; ez = 0;
      end
      run_div(a[N-1:0], b[N-1:0], eq[N-1:0], er[N-1:0], ez[0], 1'b0,
              $sformatf("rnd%0d %0d/%0d", i, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
